// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus issue FSM in front of a UART transmitter.
// Bytes leave in write order, one frame at a time, paced by tx_done rising.
module uart_tx_feeder #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     tx_start,
   output logic [WIDTH-1:0]         tx_data,
   input  logic                     tx_done,
   output logic                     busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_WAIT
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             start_q, start_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             done_dly_q, done_dly_d;
   logic             push, pop, done_rise;

   // full/empty come from the registered count only, no bypass
   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign pop       = (state_q == S_IDLE) && !empty;
   assign push      = wr_en && (!full || pop);
   assign done_rise = tx_done && !done_dly_q;

   assign count    = count_q;
   assign overflow = ovf_q;
   assign tx_start = start_q;
   assign tx_data  = data_q;
   assign busy     = (state_q != S_IDLE);

   // FIFO bookkeeping: write pointer, occupancy and dropped-push flag
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      ovf_d      = wr_en && full && !pop;
      done_dly_d = tx_done;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // issue FSM: pop one byte, pulse start, then wait for a fresh done edge
   always_comb begin
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      start_d  = 1'b0;
      data_d   = data_q;
      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               state_d  = S_SEND;
               data_d   = mem_q[rd_ptr_q];
               rd_ptr_d = rd_ptr_q + AW'(1);
               start_d  = 1'b1;
            end
         end
         S_SEND: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (done_rise) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // control and output registers; reset discards queued bytes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         start_q    <= 1'b0;
         data_q     <= '0;
         done_dly_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         start_q    <= start_d;
         data_q     <= data_d;
         done_dly_q <= done_dly_d;
      end
   end

   // byte storage needs no reset: the pointers define what is valid
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed and random checks of the UART feeder.
// Frame order is checked against a queue of accepted bytes.
module tb_uart_tx_feeder;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic [3:0] count;
   logic       overflow;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_done;
   logic       busy;

   int         checks;
   int         failures;
   int         ovf_cnt;
   int         dly;
   bit         auto_tx;
   logic [7:0] got_q [$];
   logic [7:0] ref_q [$];
   logic [7:0] t2 [10];
   logic [7:0] b;
   logic [7:0] bc;
   int         n0;
   int         ov0;
   int         k;

   uart_tx_feeder #(.DEPTH(8), .WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_done  (tx_done),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // one clock; sample on the falling edge, then model the transmitter
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      if (tx_start) got_q.push_back(tx_data);
      if (overflow) ovf_cnt++;
      if (auto_tx) begin
         if (tx_done) tx_done = 1'b0;
         else if (dly > 0) begin
            dly--;
            if (dly == 0) tx_done = 1'b1;
         end
         if (tx_start) dly = int'($urandom_range(1, 4));
      end
   endtask

   task automatic finish_frame();
      tx_done = 1'b0;
      cyc();
      cyc();
      tx_done = 1'b1;
      cyc();
      tx_done = 1'b0;
   endtask

   initial begin
      checks = 0; failures = 0; ovf_cnt = 0; dly = 0; auto_tx = 1'b0;
      rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_done = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_start", 32'(tx_start), 0);
      chk("rst_data", 32'(tx_data), 0);
      chk("rst_ovf", 32'(overflow), 0);
      rst = 1'b0;
      cyc();

      // single byte latency and hold
      wr_en = 1'b1; wr_data = 8'h5A; ref_q.push_back(8'h5A);
      cyc();
      wr_en = 1'b0;
      chk("t1_count1", 32'(count), 1);
      chk("t1_nostart", 32'(tx_start), 0);
      chk("t1_idle", 32'(busy), 0);
      cyc();
      chk("t1_start", 32'(tx_start), 1);
      chk("t1_data", 32'(tx_data), 32'h5A);
      chk("t1_count0", 32'(count), 0);
      chk("t1_busy", 32'(busy), 1);
      cyc();
      chk("t1_start_1cyc", 32'(tx_start), 0);
      chk("t1_data_hold", 32'(tx_data), 32'h5A);
      repeat (3) cyc();
      chk("t1_waiting", 32'(busy), 1);
      tx_done = 1'b1;
      cyc();
      chk("t1_done_idle", 32'(busy), 0);
      tx_done = 1'b0;
      cyc();
      chk("t1_idle2", 32'(busy), 0);
      chk("t1_data_after", 32'(tx_data), 32'h5A);

      // fill to full and overflow
      for (int i = 0; i < 10; i++) begin
         t2[i] = 8'($urandom);
         wr_en = 1'b1; wr_data = t2[i];
         if (i < 9) ref_q.push_back(t2[i]);
         cyc();
         if (i == 8) begin
            chk("t2_count8", 32'(count), 8);
            chk("t2_full", 32'(full), 1);
            chk("t2_no_ovf", 32'(overflow), 0);
         end
         if (i == 9) begin
            chk("t2_ovf", 32'(overflow), 1);
            chk("t2_count_stays", 32'(count), 8);
         end
      end
      wr_en = 1'b0;
      cyc();
      chk("t2_ovf_1cyc", 32'(overflow), 0);
      chk("t2_count_after", 32'(count), 8);
      chk("t2_ovf_total", 32'(ovf_cnt), 1);

      // push and pop in the same cycle while full
      tx_done = 1'b1;
      cyc();
      chk("t3_idle", 32'(busy), 0);
      chk("t3_full", 32'(full), 1);
      tx_done = 1'b0;
      b = 8'($urandom);
      wr_en = 1'b1; wr_data = b; ref_q.push_back(b);
      cyc();
      wr_en = 1'b0;
      chk("t3_count", 32'(count), 8);
      chk("t3_no_ovf", 32'(overflow), 0);
      chk("t3_start", 32'(tx_start), 1);
      chk("t3_data", 32'(tx_data), 32'(t2[1]));
      for (int i = 0; i < 8; i++) begin
         finish_frame();
         cyc();
      end
      finish_frame();
      chk("t3_empty", 32'(empty), 1);
      chk("t3_busy", 32'(busy), 0);

      // done held high counts once
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         if (i == 2) bc = b;
         wr_en = 1'b1; wr_data = b; ref_q.push_back(b);
         cyc();
      end
      wr_en = 1'b0;
      n0 = got_q.size();
      tx_done = 1'b1;
      repeat (20) cyc();
      chk("t4_one_start", 32'(got_q.size() - n0), 1);
      chk("t4_busy", 32'(busy), 1);
      chk("t4_count", 32'(count), 1);
      tx_done = 1'b0;
      cyc();
      chk("t4_fall_busy", 32'(busy), 1);
      chk("t4_fall_count", 32'(count), 1);
      tx_done = 1'b1;
      cyc();
      chk("t4_rise_idle", 32'(busy), 0);
      tx_done = 1'b0;
      cyc();
      chk("t4_next_start", 32'(tx_start), 1);
      chk("t4_next_data", 32'(tx_data), 32'(bc));
      finish_frame();
      chk("t4_empty", 32'(empty), 1);

      // reset in WAIT with bytes queued
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom);
         if (i == 0) ref_q.push_back(b);
         wr_en = 1'b1; wr_data = b;
         cyc();
      end
      wr_en = 1'b0;
      cyc();
      chk("t5_count3", 32'(count), 3);
      chk("t5_busy", 32'(busy), 1);
      rst = 1'b1;
      #1;
      chk("t5_async_count", 32'(count), 0);
      chk("t5_async_busy", 32'(busy), 0);
      cyc();
      chk("t5_empty", 32'(empty), 1);
      chk("t5_count", 32'(count), 0);
      chk("t5_start", 32'(tx_start), 0);
      chk("t5_idle", 32'(busy), 0);
      chk("t5_data", 32'(tx_data), 0);
      rst = 1'b0;
      n0 = got_q.size();
      for (int i = 0; i < 10; i++) begin
         cyc();
         tx_done = ~tx_done;
      end
      tx_done = 1'b0;
      cyc();
      chk("t5_no_start", 32'(got_q.size() - n0), 0);
      chk("t5_still_idle", 32'(busy), 0);

      // random burst with a transmitter model
      auto_tx = 1'b1;
      dly = 0;
      ov0 = ovf_cnt;
      for (int i = 0; i < 10; i++) begin
         b = 8'($urandom_range(10, 200));
         ref_q.push_back(b);
         wr_en = 1'b1; wr_data = b;
         cyc();
      end
      wr_en = 1'b0;
      k = 0;
      while (got_q.size() < ref_q.size() && k < 1000) begin
         cyc();
         k++;
      end
      chk("t6_in_time", 32'(k < 1000), 1);
      while (busy && k < 2000) begin
         cyc();
         k++;
      end
      chk("t6_idle", 32'(busy), 0);
      chk("t6_no_ovf", 32'(ovf_cnt - ov0), 0);
      auto_tx = 1'b0;

      chk("order_size", 32'(got_q.size()), 32'(ref_q.size()));
      for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) begin
         chk($sformatf("order[%0d]", i), 32'(got_q[i]), 32'(ref_q[i]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
